moon_dash_ctrl: RTL
===================

Name: moon_dash_ctrl

Overview:
Motion sequencer for the moon boss sprite. Owns the moon's position registers and runs a repeating attack cycle: hold at home, aim at the player, dash in a straight fixed-point line, rest at the playfield border, then re-aim. Positions feed the moon renderer (sprite ROM and cover logic) and the collision unit. Movement is paced by a game tick derived from the system clock and a difficulty-driven speed offset.

Parameters:
MAX_X, 384, playfield width in px; legal x is 0..MAX_X-1
MAX_Y, 448, playfield height in px; legal y is 0..MAX_Y-1
HOME_X, 192, x position after reset
HOME_Y, 100, y position after reset
TICK_DIV, 4000000, base tick period in clk cycles
WAIT_TICKS, 60, ticks spent in HOLD and REST before aiming
FRAC, 10, fractional bits of the position and velocity accumulators
STEP_SHIFT, 6, velocity = delta / 2^STEP_SHIFT px per tick
HOMING_TICKS, 16, re-aim interval (optional feature only)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  1 = run; 0 = freeze tick counter and FSM
player_x  in  10  player x px, sampled in AIM
player_y  in  10  player y px, sampled in AIM
speed_offset  in  26  subtracted from TICK_DIV to shorten the tick period
moon_x  out  10  integer x px of the moon centre
moon_y  out  10  integer y px of the moon centre
state  out  2  0=HOLD, 1=AIM, 2=DASH, 3=REST
dash_start  out  1  one-cycle pulse on the first DASH cycle
on_border  out  1  high while in REST

Behaviour:
- Reset (async) sets: state=HOLD, tick counter=0, wait counter=0, pos=(HOME_X,HOME_Y) with fraction 0, velocity=0, dash_start=0, on_border=0.
- Tick period P = TICK_DIV - speed_offset. If speed_offset >= TICK_DIV, P is forced to 1.
- Tick generation: the counter increments while enable=1. When counter >= P-1, tick=1 for that cycle and the counter returns to 0. This also covers a mid-period reduction of speed_offset.
- enable=0: tick counter, wait counter, FSM and position all hold. dash_start is held at 0.
- Position is stored as unsigned (10+FRAC)-bit fixed point. moon_x and moon_y are the integer parts (floor).
- Velocity is stored as signed (11+FRAC)-bit per axis.
- HOLD: counts ticks. After WAIT_TICKS ticks, go to AIM.
- AIM: lasts exactly one clk cycle.
  - dx = player_x - moon_x and dy = player_y - moon_y, both signed 11-bit.
  - vx = (dx <<< FRAC) >>> STEP_SHIFT, arithmetic shift; vy is computed the same way.
  - If dx = dy = 0, use vx=0 and vy=+(1<<FRAC) (dash straight down).
  - Next state is DASH; dash_start=1 on the following cycle.
- DASH: on each tick, pos += v, computed signed and at full width.
  - If a result is < 0 it clamps to 0. If a result is > limit-1 it clamps to (limit-1) with fraction 0.
  - If either axis clamped on this tick, go to REST on that same tick. Both axes are clamped independently.
- REST: on_border=1 and the wait counter runs. After WAIT_TICKS ticks, go to AIM (not HOLD), re-aiming from the border position.
- Wait counter clears on every state entry.
- Reset asserted mid-dash returns the block immediately to home/HOLD. No partial move is committed.
- player_x/player_y are ignored outside AIM (and outside re-aim when MOON_HOMING_EN is defined).

Optional Feature:
MOON_HOMING_EN
- Defined: DASH recomputes vx,vy from the current moon and player positions every HOMING_TICKS ticks, using the AIM rules. This happens on the same tick as the move, after the move. The zero-delta rule still applies. Border clamping still ends the dash.
- Undefined: the velocity latched in AIM is constant for the whole dash, and no re-aim logic is synthesised.

Test Plan:
- All sim tests use TICK_DIV=4, WAIT_TICKS=2.
- Reset: assert reset mid-run → next sample shows moon=(192,100), state=HOLD, on_border=0, dash_start=0.
- Tick pacing: speed_offset=0 → tick every 4 clk; speed_offset=2 → every 2 clk; speed_offset=10 → every clk (P forced to 1).
- Straight dash: player=(192,400) → vy=4800 (4.6875 px/tick); moon_y=104 after tick 1; 446 after tick 74; tick 75 clamps to 447, state=REST, on_border=1.
- Zero delta: player=(192,100) at AIM → vy=+1 px/tick; moon_y=101,102,... and moon_x stays 192.
- Right border: player=(383,100) → vx=3056; moon_x clamps to 383 on the clamping tick; moon_y stays 100; REST; after 2 ticks → AIM, then a dash_start pulse.
- Freeze: enable=0 for 50 cycles mid-DASH → moon_x/moon_y/state unchanged. Motion resumes with the same velocity after enable=1.

Source files
------------

// File: rtl/moon_dash_ctrl_if.sv
// Control/status bundle between the moon motion sequencer and its consumers.
// The slave side is the sequencer; the master side drives the player position and pacing.
interface moon_dash_ctrl_if;
    logic        enable;
    logic [9:0]  player_x;
    logic [9:0]  player_y;
    logic [25:0] speed_offset;
    logic [9:0]  moon_x;
    logic [9:0]  moon_y;
    logic [1:0]  state;
    logic        dash_start;
    logic        on_border;

    modport master (
        output enable, player_x, player_y, speed_offset,
        input  moon_x, moon_y, state, dash_start, on_border
    );

    modport slave (
        input  enable, player_x, player_y, speed_offset,
        output moon_x, moon_y, state, dash_start, on_border
    );
endinterface

// File: rtl/moon_dash_ctrl.sv
// Moon boss motion sequencer: HOLD -> AIM -> DASH -> REST -> AIM ... with fixed-point motion.
// Optional mid-dash re-aiming is enabled by defining MOON_HOMING_EN.
module moon_dash_ctrl #(
    parameter int MAX_X        = 384,
    parameter int MAX_Y        = 448,
    parameter int HOME_X       = 192,
    parameter int HOME_Y       = 100,
    parameter int TICK_DIV     = 4000000,
    parameter int WAIT_TICKS   = 60,
    parameter int FRAC         = 10,
    parameter int STEP_SHIFT   = 6,
    parameter int HOMING_TICKS = 16
) (
    input  logic            clk,
    input  logic            reset,
    moon_dash_ctrl_if.slave bus
);
    localparam int PW = 10 + FRAC;
    localparam int VW = 11 + FRAC;
    localparam int SW = PW + 2;
    localparam int CW = 26;
    localparam int WW = (WAIT_TICKS > 1) ? $clog2(WAIT_TICKS) : 1;

    localparam logic [CW-1:0] TICK_DIV_C = CW'(TICK_DIV);
    localparam logic [WW-1:0] WAIT_LAST  = WW'(WAIT_TICKS - 1);
    localparam logic [PW-1:0] HOME_X_FX  = PW'(HOME_X << FRAC);
    localparam logic [PW-1:0] HOME_Y_FX  = PW'(HOME_Y << FRAC);

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        AIM  = 2'd1,
        DASH = 2'd2,
        REST = 2'd3
    } state_t;

    state_t                state_reg, state_next;
    logic [CW-1:0]         tick_cnt_reg, tick_cnt_next;
    logic [CW-1:0]         period;
    logic                  tick;
    logic [WW-1:0]         wait_cnt_reg, wait_cnt_next;
    logic                  dash_start_reg, dash_start_next;

    logic [PW-1:0]         pos_reg   [2];
    logic [PW-1:0]         pos_next  [2];
    logic signed [VW-1:0]  vel_reg   [2];
    logic signed [VW-1:0]  vel_next  [2];

    logic [PW-1:0]         step_pos  [2];
    logic                  clamp     [2];
    logic [9:0]            player    [2];
    logic [9:0]            aim_src   [2];
    logic signed [10:0]    delta     [2];
    logic signed [VW-1:0]  aim_raw   [2];
    logic signed [VW-1:0]  aim_vel   [2];
    logic                  aim_zero;

    assign player[0] = bus.player_x;
    assign player[1] = bus.player_y;

    // Game tick; the >= compare also recovers when the period shrinks mid-count.
    always_comb begin
        period        = (bus.speed_offset >= TICK_DIV_C) ? CW'(1) : (TICK_DIV_C - bus.speed_offset);
        tick          = bus.enable && (tick_cnt_reg >= (period - CW'(1)));
        tick_cnt_next = tick_cnt_reg;
        if (bus.enable) begin
            tick_cnt_next = tick ? '0 : (tick_cnt_reg + CW'(1));
        end
    end

`ifdef MOON_HOMING_EN
    localparam int HW = (HOMING_TICKS > 1) ? $clog2(HOMING_TICKS) : 1;
    localparam logic [HW-1:0] HOMING_LAST = HW'(HOMING_TICKS - 1);

    logic [HW-1:0] homing_cnt_reg, homing_cnt_next;
    logic          homing_due;

    assign homing_due = (homing_cnt_reg == HOMING_LAST);

    always_comb begin
        homing_cnt_next = homing_cnt_reg;
        if (bus.enable) begin
            if (state_reg == AIM) begin
                homing_cnt_next = '0;
            end else if ((state_reg == DASH) && tick) begin
                homing_cnt_next = homing_due ? '0 : (homing_cnt_reg + HW'(1));
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            homing_cnt_reg <= '0;
        end else begin
            homing_cnt_reg <= homing_cnt_next;
        end
    end
`endif

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_axis
            localparam int LIMIT = (gi == 0) ? MAX_X : MAX_Y;
            localparam logic signed [SW-1:0] UPPER    = SW'(LIMIT << FRAC);
            localparam logic [PW-1:0]        CLAMP_HI = PW'((LIMIT - 1) << FRAC);

            logic signed [SW-1:0] sum;
            logic signed [VW-1:0] dext;
            logic                 lo_hit;
            logic                 hi_hit;

            // Full-width signed move; anything past the last legal pixel pins to its integer edge.
            assign sum    = $signed({2'b00, pos_reg[gi]})
                          + $signed({{(SW-VW){vel_reg[gi][VW-1]}}, vel_reg[gi]});
            assign lo_hit = sum[SW-1];
            assign hi_hit = !lo_hit && (sum >= UPPER);
            assign clamp[gi]    = lo_hit || hi_hit;
            assign step_pos[gi] = lo_hit ? '0 : (hi_hit ? CLAMP_HI : sum[PW-1:0]);

`ifdef MOON_HOMING_EN
            // Mid-dash re-aim uses the position after this tick's move.
            assign aim_src[gi] = (state_reg == DASH) ? step_pos[gi][PW-1:FRAC]
                                                     : pos_reg[gi][PW-1:FRAC];
`else
            assign aim_src[gi] = pos_reg[gi][PW-1:FRAC];
`endif

            assign delta[gi]   = $signed({1'b0, player[gi]}) - $signed({1'b0, aim_src[gi]});
            assign dext        = {{(VW-11){delta[gi][10]}}, delta[gi]};
            assign aim_raw[gi] = (dext <<< FRAC) >>> STEP_SHIFT;
        end
    endgenerate

    // A player sitting exactly on the moon would give a zero velocity; dash straight down instead.
    assign aim_zero   = (delta[0] == 11'sd0) && (delta[1] == 11'sd0);
    assign aim_vel[0] = aim_zero ? '0 : aim_raw[0];
    assign aim_vel[1] = aim_zero ? VW'(1 << FRAC) : aim_raw[1];

    always_comb begin
        state_next      = state_reg;
        wait_cnt_next   = wait_cnt_reg;
        dash_start_next = 1'b0;
        pos_next[0]     = pos_reg[0];
        pos_next[1]     = pos_reg[1];
        vel_next[0]     = vel_reg[0];
        vel_next[1]     = vel_reg[1];

        if (bus.enable) begin
            case (state_reg)
                HOLD, REST: begin
                    if (tick) begin
                        if (wait_cnt_reg == WAIT_LAST) begin
                            state_next    = AIM;
                            wait_cnt_next = '0;
                        end else begin
                            wait_cnt_next = wait_cnt_reg + WW'(1);
                        end
                    end
                end
                AIM: begin
                    vel_next[0]     = aim_vel[0];
                    vel_next[1]     = aim_vel[1];
                    state_next      = DASH;
                    wait_cnt_next   = '0;
                    dash_start_next = 1'b1;
                end
                DASH: begin
                    if (tick) begin
                        pos_next[0] = step_pos[0];
                        pos_next[1] = step_pos[1];
`ifdef MOON_HOMING_EN
                        if (homing_due) begin
                            vel_next[0] = aim_vel[0];
                            vel_next[1] = aim_vel[1];
                        end
`endif
                        if (clamp[0] || clamp[1]) begin
                            state_next    = REST;
                            wait_cnt_next = '0;
                        end
                    end
                end
                default: begin
                    state_next = HOLD;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= HOLD;
            tick_cnt_reg   <= '0;
            wait_cnt_reg   <= '0;
            dash_start_reg <= 1'b0;
            pos_reg[0]     <= HOME_X_FX;
            pos_reg[1]     <= HOME_Y_FX;
            vel_reg[0]     <= '0;
            vel_reg[1]     <= '0;
        end else begin
            state_reg      <= state_next;
            tick_cnt_reg   <= tick_cnt_next;
            wait_cnt_reg   <= wait_cnt_next;
            dash_start_reg <= dash_start_next;
            pos_reg[0]     <= pos_next[0];
            pos_reg[1]     <= pos_next[1];
            vel_reg[0]     <= vel_next[0];
            vel_reg[1]     <= vel_next[1];
        end
    end

    assign bus.moon_x     = pos_reg[0][PW-1:FRAC];
    assign bus.moon_y     = pos_reg[1][PW-1:FRAC];
    assign bus.state      = state_reg;
    assign bus.dash_start = dash_start_reg;
    assign bus.on_border  = (state_reg == REST);
endmodule
